// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the unified I/D memory arbiter.
// The master modport is the arbiter. The slave modport is the surrounding pipeline plus the memory.
interface mem_port_arbiter_if;
  logic [31:0] PCF;
  logic        FlushD;
  logic [31:0] InstrF;
  logic        StallFetchF;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [3:0]  ByteEnM;
  logic [31:0] ReadDataM;
  logic        StallMemM;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemBe;
  logic [31:0] MemRData;

  modport master (
    input  PCF, FlushD, MemReadM, MemWriteM, ALUResultM, WriteDataM, ByteEnM, MemRData,
    output InstrF, StallFetchF, ReadDataM, StallMemM, MemReq, MemWe, MemAddr, MemWData, MemBe
  );

  modport slave (
    output PCF, FlushD, MemReadM, MemWriteM, ALUResultM, WriteDataM, ByteEnM, MemRData,
    input  InstrF, StallFetchF, ReadDataM, StallMemM, MemReq, MemWe, MemAddr, MemWData, MemBe
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port unified I/D memory arbiter for the RV32I pipeline; hides a fixed LAT-cycle latency.
// Defining MEMARB_IBUF_EN adds a one-entry fetch buffer that avoids refetching a held PC.
module mem_port_arbiter #(
  parameter int unsigned LAT = 2
) (
  input logic                 clk,
  input logic                 reset,
  mem_port_arbiter_if.master  bus
);

  localparam int unsigned      CNT_W    = 3;
  localparam logic [31:0]      NOP      = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);
  localparam bit               SINGLE   = (LAT == 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_alat;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      w_alat_nxt;

  logic        w_data_req;
  logic        w_last;
  logic        w_buf_hit;
  logic [31:0] w_buf_instr;
  logic        w_req;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic        w_issue;
  logic        w_issue_d;
  logic        w_fetch_done;
  logic        w_data_done;
  logic [31:0] w_fetch_addr;
  logic        w_fetch_ok;

  assign w_data_req = bus.MemReadM | bus.MemWriteM;
  assign w_last     = (r_cnt == CNT_LAST);
  // A completed fetch only counts if the PC did not move away while it was in flight.
  assign w_fetch_ok = w_fetch_done && (bus.PCF == w_fetch_addr);

`ifdef MEMARB_IBUF_EN
  logic        r_buf_vld;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_instr;
  logic        w_buf_inval;

  assign w_buf_hit   = r_buf_vld && (bus.PCF == r_buf_pc);
  assign w_buf_instr = r_buf_instr;
  // A store into the buffered word makes the buffered copy stale.
  assign w_buf_inval = bus.FlushD ||
                       (w_issue_d && bus.MemWriteM && (bus.ALUResultM[31:2] == r_buf_pc[31:2]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf_vld   <= 1'b0;
      r_buf_pc    <= '0;
      r_buf_instr <= '0;
    end else if (w_buf_inval) begin
      r_buf_vld   <= 1'b0;
    end else if (w_fetch_ok) begin
      r_buf_vld   <= 1'b1;
      r_buf_pc    <= bus.PCF;
      r_buf_instr <= bus.MemRData;
    end
  end
`else
  logic w_unused_flush;

  assign w_unused_flush = bus.FlushD;
  assign w_buf_hit      = 1'b0;
  assign w_buf_instr    = NOP;
`endif

  // Issue and sequencing: data beats fetch in IDLE, and a busy access always runs to completion.
  always_comb begin
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_addr       = r_alat;
    w_wdata      = '0;
    w_be         = 4'hF;
    w_issue      = 1'b0;
    w_issue_d    = 1'b0;
    w_fetch_done = 1'b0;
    w_data_done  = 1'b0;
    w_fetch_addr = r_alat;
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_alat_nxt   = r_alat;

    case (r_state)
      IDLE: begin
        if (w_data_req) begin
          w_req       = 1'b1;
          w_addr      = bus.ALUResultM;
          w_we        = bus.MemWriteM;
          w_wdata     = bus.WriteDataM;
          w_be        = bus.MemWriteM ? bus.ByteEnM : 4'hF;
          w_issue     = 1'b1;
          w_issue_d   = 1'b1;
          w_data_done = SINGLE;
        end else if (!w_buf_hit) begin
          w_req        = 1'b1;
          w_addr       = bus.PCF;
          w_fetch_addr = bus.PCF;
          w_issue      = 1'b1;
          w_fetch_done = SINGLE;
        end
        if (w_issue) begin
          w_alat_nxt = w_addr;
          if (!SINGLE) begin
            w_state_nxt = w_issue_d ? BUSY_D : BUSY_F;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      BUSY_F: begin
        w_req        = 1'b1;
        w_fetch_done = w_last;
        if (w_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      BUSY_D: begin
        w_req       = 1'b1;
        w_we        = bus.MemWriteM;
        w_wdata     = bus.WriteDataM;
        w_be        = bus.MemWriteM ? bus.ByteEnM : 4'hF;
        w_data_done = w_last;
        if (w_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_alat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_alat  <= w_alat_nxt;
    end
  end

  // Outputs are combinational; reset forces the memory port quiet and the fetch side stalled.
  assign bus.MemReq      = w_req & ~reset;
  assign bus.MemWe       = w_we & ~reset;
  assign bus.MemAddr     = w_addr;
  assign bus.MemWData    = w_wdata;
  assign bus.MemBe       = w_be;
  assign bus.StallMemM   = w_data_req & ~w_data_done;
  assign bus.StallFetchF = reset | (~w_fetch_ok & ~w_buf_hit);
  assign bus.InstrF      = reset      ? NOP          :
                           w_fetch_ok ? bus.MemRData :
                           w_buf_hit  ? w_buf_instr  : NOP;
  assign bus.ReadDataM   = (!reset && w_data_done && bus.MemReadM) ? bus.MemRData : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter at LAT=1, 2 and 3, with a combinational memory model.
// Build with MEMARB_IBUF_EN defined to exercise the fetch buffer.
`define DEF_IN(i) i.PCF = '0; i.FlushD = 1'b0; i.MemReadM = 1'b0; i.MemWriteM = 1'b0; i.ALUResultM = '0; i.WriteDataM = '0; i.ByteEnM = '0;

module tb_mem_port_arbiter;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef MEMARB_IBUF_EN
  localparam bit IBUF = 1'b1;
`else
  localparam bit IBUF = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst1, rst2, rst3;
  int   n_run;
  int   n_fail;
  exp_t sb[$];

  mem_port_arbiter_if if1 ();
  mem_port_arbiter_if if2 ();
  mem_port_arbiter_if if3 ();

  mem_port_arbiter #(.LAT(1)) u_lat1 (.clk(clk), .reset(rst1), .bus(if1));
  mem_port_arbiter #(.LAT(2)) u_lat2 (.clk(clk), .reset(rst2), .bus(if2));
  mem_port_arbiter #(.LAT(3)) u_lat3 (.clk(clk), .reset(rst3), .bus(if3));

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Memory model: read data is a fixed function of the address currently on the port.
  assign if1.MemRData = mem_f(if1.MemAddr);
  assign if2.MemRData = mem_f(if2.MemAddr);
  assign if3.MemRData = mem_f(if3.MemAddr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    exp_t e;
    n_run++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (e.tag == tag && obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h (queued %s)", tag, obs, e.val, e.tag);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst1 = 1'b1;
    rst2 = 1'b1;
    rst3 = 1'b1;
    `DEF_IN(if1)
    `DEF_IN(if2)
    `DEF_IN(if3)
    if1.MemWriteM  = 1'b1;
    if3.MemReadM   = 1'b1;
    if3.ALUResultM = 32'h100;

    // Reset holds the port quiet even with memory ops pending
    push("rst_req1", 32'd0); push("rst_we1", 32'd0); push("rst_sf1", 32'd1); push("rst_instr1", NOP);
    push("rst_req3", 32'd0); push("rst_rd3", 32'd0); push("rst_sf3", 32'd1); push("rst_instr3", NOP);
    @(negedge clk);
    chk("rst_req1", 32'(if1.MemReq)); chk("rst_we1", 32'(if1.MemWe));
    chk("rst_sf1", 32'(if1.StallFetchF)); chk("rst_instr1", if1.InstrF);
    chk("rst_req3", 32'(if3.MemReq)); chk("rst_rd3", if3.ReadDataM);
    chk("rst_sf3", 32'(if3.StallFetchF)); chk("rst_instr3", if3.InstrF);
    tick();
    rst1 = 1'b0;
    if1.MemWriteM = 1'b0;

    // LAT=1: one fetch per cycle, no stalls
    for (int i = 0; i < 3; i++) begin
      push("t1_req", 32'd1); push("t1_addr", 32'(i * 4)); push("t1_sf", 32'd0); push("t1_instr", mem_f(32'(i * 4)));
    end
    for (int i = 0; i < 3; i++) begin
      if1.PCF = 32'(i * 4);
      @(negedge clk);
      chk("t1_req", 32'(if1.MemReq)); chk("t1_addr", if1.MemAddr);
      chk("t1_sf", 32'(if1.StallFetchF)); chk("t1_instr", if1.InstrF);
      tick();
    end

    // LAT=3: load at 0x100 from IDLE, then the refetch of PC 0
    rst3 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      push("t2_sm", (c < 2) ? 32'd1 : 32'd0);
      push("t2_rd", (c == 2) ? mem_f(32'h100) : 32'd0);
      push("t2_sf", (c != 5) ? 32'd1 : 32'd0);
      push("t2_addr", (c < 3) ? 32'h100 : 32'h0);
      push("t2_instr", (c == 5) ? mem_f(32'h0) : NOP);
    end
    for (int c = 0; c < 6; c++) begin
      if (c == 3) if3.MemReadM = 1'b0;
      @(negedge clk);
      chk("t2_sm", 32'(if3.StallMemM)); chk("t2_rd", if3.ReadDataM); chk("t2_sf", 32'(if3.StallFetchF));
      chk("t2_addr", if3.MemAddr); chk("t2_instr", if3.InstrF);
      tick();
    end

    // LAT=3: store arriving during a fetch waits for it, then runs its own LAT cycles
    for (int c = 0; c < 6; c++) begin
      push("t3_addr", (c < 3) ? 32'h20 : 32'h40);
      push("t3_we", (c < 3) ? 32'd0 : 32'd1);
      push("t3_be", (c < 3) ? 32'hF : 32'h3);
      push("t3_sm", (c == 0 || c == 5) ? 32'd0 : 32'd1);
      push("t3_sf", (c < 2) ? 32'd1 : (c == 2) ? 32'd0 : (IBUF ? 32'd0 : 32'd1));
      push("t3_instr", (c == 2 || (c > 2 && IBUF)) ? mem_f(32'h20) : NOP);
      if (c == 4) push("t3_wdata", 32'hDEAD_BEEF);
    end
    if3.PCF = 32'h20;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin
        if3.MemWriteM  = 1'b1;
        if3.ALUResultM = 32'h40;
        if3.WriteDataM = 32'hDEAD_BEEF;
        if3.ByteEnM    = 4'b0011;
      end
      @(negedge clk);
      chk("t3_addr", if3.MemAddr); chk("t3_we", 32'(if3.MemWe)); chk("t3_be", 32'(if3.MemBe));
      chk("t3_sm", 32'(if3.StallMemM)); chk("t3_sf", 32'(if3.StallFetchF)); chk("t3_instr", if3.InstrF);
      if (c == 4) chk("t3_wdata", if3.MemWData);
      tick();
    end

    // LAT=3: reset in the middle of a load, then a clean fetch after release
    if3.MemWriteM  = 1'b0;
    if3.MemReadM   = 1'b1;
    if3.ALUResultM = 32'h200;
    push("t5_issue_addr", 32'h200); push("t5_issue_req", 32'd1); push("t5_busy_req", 32'd1);
    push("t5_rst_req", 32'd0); push("t5_rst_sf", 32'd1); push("t5_rst_rd", 32'd0);
    for (int c = 0; c < 3; c++) begin
      push("t5_addr", 32'h30); push("t5_req", 32'd1);
      push("t5_sf", (c < 2) ? 32'd1 : 32'd0); push("t5_instr", (c < 2) ? NOP : mem_f(32'h30));
    end
    @(negedge clk);
    chk("t5_issue_addr", if3.MemAddr); chk("t5_issue_req", 32'(if3.MemReq));
    tick();
    @(negedge clk);
    chk("t5_busy_req", 32'(if3.MemReq));
    #2 rst3 = 1'b1;
    #1;
    chk("t5_rst_req", 32'(if3.MemReq)); chk("t5_rst_sf", 32'(if3.StallFetchF)); chk("t5_rst_rd", if3.ReadDataM);
    tick();
    rst3 = 1'b0;
    if3.MemReadM = 1'b0;
    if3.PCF = 32'h30;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t5_addr", if3.MemAddr); chk("t5_req", 32'(if3.MemReq));
      chk("t5_sf", 32'(if3.StallFetchF)); chk("t5_instr", if3.InstrF);
      tick();
    end

    // LAT=2: PC redirect mid-fetch discards the stale word and refetches the new PC
    rst2 = 1'b0;
    if2.PCF = 32'h20;
    for (int c = 0; c < 4; c++) begin
      push("t4_addr", (c < 2) ? 32'h20 : 32'h80);
      push("t4_sf", (c < 3) ? 32'd1 : 32'd0);
      push("t4_instr", (c < 3) ? NOP : mem_f(32'h80));
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 1) if2.PCF = 32'h80;
      @(negedge clk);
      chk("t4_addr", if2.MemAddr); chk("t4_sf", 32'(if2.StallFetchF)); chk("t4_instr", if2.InstrF);
      tick();
    end

`ifdef MEMARB_IBUF_EN
    // LAT=2 with buffer: held PC hits, a store to it and FlushD both invalidate
    for (int c = 0; c < 8; c++) begin
      push("t6_req", (c == 0 || c == 1 || c == 6) ? 32'd0 : 32'd1);
      push("t6_sf", (c == 3 || c == 4 || c == 7) ? 32'd1 : 32'd0);
      push("t6_we", (c == 2 || c == 3) ? 32'd1 : 32'd0);
      push("t6_instr", (c == 3 || c == 4 || c == 7) ? NOP : mem_f(32'h80));
    end
    for (int c = 0; c < 8; c++) begin
      if (c == 2) begin
        if2.MemWriteM  = 1'b1;
        if2.ALUResultM = 32'h80;
        if2.WriteDataM = 32'h1234;
        if2.ByteEnM    = 4'hF;
      end
      if (c == 4) if2.MemWriteM = 1'b0;
      if (c == 6) if2.FlushD = 1'b1;
      if (c == 7) if2.FlushD = 1'b0;
      @(negedge clk);
      chk("t6_req", 32'(if2.MemReq)); chk("t6_sf", 32'(if2.StallFetchF));
      chk("t6_we", 32'(if2.MemWe)); chk("t6_instr", if2.InstrF);
      tick();
    end
`else
    // LAT=2 without buffer: a held PC is fetched again from memory
    for (int c = 0; c < 2; c++) begin
      push("t6_req", 32'd1); push("t6_addr", 32'h80);
      push("t6_sf", (c == 0) ? 32'd1 : 32'd0); push("t6_instr", (c == 0) ? NOP : mem_f(32'h80));
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t6_req", 32'(if2.MemReq)); chk("t6_addr", if2.MemAddr);
      chk("t6_sf", 32'(if2.StallFetchF)); chk("t6_instr", if2.InstrF);
      tick();
    end
`endif

    n_run++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: observed %0d leftover entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
